fetch_queue_pc: RTL

//   Parametrised successor to the single-register PC: owns the fetch PC, issues sequential

---
 rtl/fetch_queue_pc.sv | 85 ++++++++
 1 files changed

// File: rtl/fetch_queue_pc.sv
// rtl/fetch_queue_pc.sv - fetch PC with sequential imem reads buffered in a DEPTH-entry queue
// Redirect flushes the queue and restarts fetch; halt stops new reads while decode drains.
module fetch_queue_pc #(
  parameter int WORD_W = 32,
  parameter int DEPTH = 4,
  parameter logic [WORD_W-1:0] PC_RESET = '0
) (
  input  logic                       CLK,
  input  logic                       RST,
  output logic                       imemREN,
  output logic [WORD_W-1:0]          imemaddr,
  input  logic                       ihit,
  input  logic [WORD_W-1:0]          imemload,
  input  logic                       redirect,
  input  logic [WORD_W-1:0]          redirect_addr,
  input  logic                       halt,
  input  logic                       deq,
  output logic                       q_valid,
  output logic [WORD_W-1:0]          q_instr,
  output logic [WORD_W-1:0]          q_pc,
  output logic [WORD_W-1:0]          q_npc,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WORD_W-1:0] fpc;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [WORD_W-1:0] instr_q [DEPTH];
  logic [WORD_W-1:0] pc_q    [DEPTH];
  logic              enq;
  logic              deq_ok;

  // Request depends only on registered occupancy, never on deq or redirect.
  assign imemREN  = !RST && !halt && (count < CW'(DEPTH));
  assign imemaddr = fpc;

  assign enq    = imemREN && ihit && !redirect;
  assign deq_ok = deq && (count != '0) && !redirect;

  assign q_valid = (count != '0);
  assign q_count = count;
  assign q_instr = instr_q[rd_ptr];
  assign q_pc    = pc_q[rd_ptr];
  assign q_npc   = pc_q[rd_ptr] + WORD_W'(4);

  always_ff @(posedge CLK) begin
    if (RST) begin
      fpc    <= PC_RESET;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      fpc    <= {redirect_addr[WORD_W-1:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        fpc    <= fpc + WORD_W'(4);
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (deq_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({enq, deq_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; q_valid gates its visibility.
  always_ff @(posedge CLK) begin
    if (enq) begin
      instr_q[wr_ptr] <= imemload;
      pc_q[wr_ptr]    <= fpc;
    end
  end

endmodule
